fpu_cvt_from_int: RTL

Multi-cycle integer-to-single-precision converter for the FPU arithmetic unit, implementing FCVT.S.W and FCVT.S.WU. It accepts a 32-bit signed or unsigned integer and produces an IEEE-754 binary32 result rounded per the RISC-V rounding mode, together with an inexact flag. Normalization is iterative, one bit per cycle, trading latency for area. The FPU control FSM drives it through a start/done handshake.

---
 rtl/fpu_cvt_from_int_pkg.sv | 28 ++
 rtl/fpu_cvt_from_int_if.sv | 36 +++
 rtl/fpu_cvt_from_int_round_decide.sv | 32 +++
 rtl/fpu_cvt_from_int.sv | 117 +++++++++++
 4 files changed

// File: rtl/fpu_cvt_from_int_pkg.sv
// Shared FPU definitions: converter FSM states, RISC-V rounding-mode
// encodings and binary32 exponent constants.
package fpu_cvt_from_int_pkg;

    typedef enum logic [1:0] {
        CVT_IDLE  = 2'd0,
        CVT_NORM  = 2'd1,
        CVT_ROUND = 2'd2
    } cvt_state_e;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int         FP32_BIAS    = 127;
    // Exponent of an integer whose leading one sits in bit 31.
    localparam logic [7:0] CVT_EXP_INIT = 8'(FP32_BIAS + 31);

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is
    // still the correct unsigned magnitude of the most negative int32.
    function automatic logic [31:0] cvtMagnitude(input logic [31:0] value,
                                                 input logic        negate);
        return negate ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/fpu_cvt_from_int_if.sv
// Request/response bundle between the FPU control FSM (master) and the
// int-to-float converter (slave).
interface fpu_cvt_from_int_if;

    logic        start_i;
    logic [31:0] int_i;
    logic        is_unsigned_i;
    logic [2:0]  rounding_mode_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        inexact_o;

    modport master (
        output start_i,
        output int_i,
        output is_unsigned_i,
        output rounding_mode_i,
        input  busy_o,
        input  done_o,
        input  result_o,
        input  inexact_o
    );

    modport slave (
        input  start_i,
        input  int_i,
        input  is_unsigned_i,
        input  rounding_mode_i,
        output busy_o,
        output done_o,
        output result_o,
        output inexact_o
    );

endinterface

// File: rtl/fpu_cvt_from_int_round_decide.sv
// Rounding increment decision from the LSB/guard/round/sticky bits of a
// truncated significand; shared by the FPU rounding stages.
module fpu_round_decide
    import fpu_cvt_from_int_pkg::*;
(
    input  logic       lsb_i,
    input  logic       guard_i,
    input  logic       round_i,
    input  logic       sticky_i,
    input  logic       sign_i,
    input  logic [2:0] rm_i,
    output logic       incr_o
);

    logic inexact;

    assign inexact = guard_i | round_i | sticky_i;

    // Pick the increment per mode; reserved encodings truncate like RTZ.
    always_comb begin
        incr_o = 1'b0;
        case (rm_i)
            RM_RNE:  incr_o = guard_i & (round_i | sticky_i | lsb_i);
            RM_RTZ:  incr_o = 1'b0;
            RM_RDN:  incr_o = sign_i & inexact;
            RM_RUP:  incr_o = ~sign_i & inexact;
            RM_RMM:  incr_o = guard_i;
            default: incr_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_cvt_from_int.sv
// FCVT.S.W / FCVT.S.WU: int32 to binary32 with one normalisation shift per
// cycle, followed by a single rounding cycle.
module fpu_cvt_from_int
    import fpu_cvt_from_int_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    fpu_cvt_from_int_if.slave cvt_if
);

    cvt_state_e  state_q;
    logic [31:0] mag_q;
    logic [7:0]  exp_q;
    logic        sign_q;
    logic [2:0]  rm_q;
    logic        zero_q;
    logic [31:0] result_q;
    logic        inexact_q;
    logic        done_q;
    logic        busy_q;

    logic        startSign;
    logic [31:0] startMag;
    logic        guardBit;
    logic        roundBit;
    logic        stickyBit;
    logic        incrRound;
    logic [24:0] sig25;
    logic [30:0] packedMagnitude;
    logic [31:0] result_d;
    logic        inexact_d;

    // Operand preparation for the accept edge.
    always_comb begin
        startSign = ~cvt_if.is_unsigned_i & cvt_if.int_i[31];
        startMag  = cvtMagnitude(cvt_if.int_i, startSign);
    end

    assign guardBit  = mag_q[7];
    assign roundBit  = mag_q[6];
    assign stickyBit = |mag_q[5:0];

    fpu_round_decide u_round_decide (
        .lsb_i    (mag_q[8]),
        .guard_i  (guardBit),
        .round_i  (roundBit),
        .sticky_i (stickyBit),
        .sign_i   (sign_q),
        .rm_i     (rm_q),
        .incr_o   (incrRound)
    );

    // Round and pack. The normalised significand carries its hidden one in
    // bit 23, so adding it onto (exp-1) in the exponent field yields exp,
    // and a rounding carry out of bit 24 yields exp+1 with a zero mantissa.
    always_comb begin
        sig25           = {1'b0, mag_q[31:8]} + {24'd0, incrRound};
        packedMagnitude = {exp_q - 8'd1, 23'd0} + {6'd0, sig25};
        result_d        = zero_q ? 32'd0 : {sign_q, packedMagnitude};
        inexact_d       = ~zero_q & (guardBit | roundBit | stickyBit);
    end

    // Control FSM and datapath registers; outputs are registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= CVT_IDLE;
            mag_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            rm_q      <= '0;
            zero_q    <= 1'b0;
            result_q  <= '0;
            inexact_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CVT_IDLE: begin
                    if (cvt_if.start_i) begin
                        sign_q  <= startSign;
                        mag_q   <= startMag;
                        exp_q   <= CVT_EXP_INIT;
                        rm_q    <= cvt_if.rounding_mode_i;
                        zero_q  <= (startMag == 32'd0);
                        busy_q  <= 1'b1;
                        state_q <= (startMag == 32'd0) ? CVT_ROUND : CVT_NORM;
                    end
                end
                CVT_NORM: begin
                    if (mag_q[31]) begin
                        state_q <= CVT_ROUND;
                    end else begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 8'd1;
                    end
                end
                CVT_ROUND: begin
                    result_q  <= result_d;
                    inexact_q <= inexact_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= CVT_IDLE;
                end
                default: begin
                    state_q <= CVT_IDLE;
                end
            endcase
        end
    end

    assign cvt_if.busy_o    = busy_q;
    assign cvt_if.done_o    = done_q;
    assign cvt_if.result_o  = result_q;
    assign cvt_if.inexact_o = inexact_q;

endmodule
